// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one 8N1 UART transmitter between NREQ byte streams.
// Define UART_TX_ARB_ID_HDR_EN to send the owner's index as a header byte before each packet.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DBIT        = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      grant,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

`ifdef UART_TX_ARB_ID_HDR_EN
    typedef enum logic [2:0] {IDLE, SEND, WAIT, HOLD, HDR} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, WAIT, HOLD} state_t;
`endif

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [IW-1:0]   g_idx, g_idx_nxt;
    logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]   rr_inc;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            last_r, last_r_nxt;
    logic [DBIT-1:0] tx_din_nxt;
    logic            tx_start_nxt;
    logic            err_nxt;
    logic            busy_nxt;
    logic [IW-1:0]   sel;
    logic            found;
`ifdef UART_TX_ARB_ID_HDR_EN
    logic            hdr_sent, hdr_sent_nxt;
`endif

    assign req_ready = (state == SEND) ? grant : '0;
    assign rr_inc    = (g_idx == IW'(NREQ - 1)) ? '0 : g_idx + 1'b1;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        int j;
        sel   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            g_idx       <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            last_r      <= 1'b0;
            tx_din      <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_TX_ARB_ID_HDR_EN
            hdr_sent    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            g_idx       <= g_idx_nxt;
            rr_ptr      <= rr_ptr_nxt;
            cnt         <= cnt_nxt;
            last_r      <= last_r_nxt;
            tx_din      <= tx_din_nxt;
            tx_start    <= tx_start_nxt;
            err_timeout <= err_nxt;
            busy        <= busy_nxt;
`ifdef UART_TX_ARB_ID_HDR_EN
            hdr_sent    <= hdr_sent_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        g_idx_nxt    = g_idx;
        rr_ptr_nxt   = rr_ptr;
        cnt_nxt      = cnt;
        last_r_nxt   = last_r;
        tx_din_nxt   = tx_din;
        tx_start_nxt = 1'b0;
        err_nxt      = 1'b0;
`ifdef UART_TX_ARB_ID_HDR_EN
        hdr_sent_nxt = hdr_sent;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    g_idx_nxt = sel;
                    grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << sel;
`ifdef UART_TX_ARB_ID_HDR_EN
                    hdr_sent_nxt = 1'b0;
                    state_nxt    = HDR;
`else
                    state_nxt    = SEND;
`endif
                end
            end
            SEND: begin
                tx_din_nxt   = req_data[g_idx*DBIT +: DBIT];
                last_r_nxt   = req_last[g_idx];
                tx_start_nxt = 1'b1;
                cnt_nxt      = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                // A done tick in the expiry cycle still completes the byte normally
                if (tx_done_tick) begin
                    if (last_r) begin
                        grant_nxt  = '0;
                        rr_ptr_nxt = rr_inc;
                        cnt_nxt    = '0;
                        state_nxt  = IDLE;
                    end else if (req_valid[g_idx]) begin
                        state_nxt = SEND;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end
                end else if (cnt == CNT_LAST) begin
                    err_nxt    = 1'b1;
                    grant_nxt  = '0;
                    rr_ptr_nxt = rr_inc;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (req_valid[g_idx]) begin
                    state_nxt = SEND;
                end else if (cnt == CNT_LAST) begin
                    err_nxt    = 1'b1;
                    grant_nxt  = '0;
                    rr_ptr_nxt = rr_inc;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef UART_TX_ARB_ID_HDR_EN
            HDR: begin
                if (!hdr_sent) begin
                    tx_din_nxt   = DBIT'(g_idx);
                    tx_start_nxt = 1'b1;
                    hdr_sent_nxt = 1'b1;
                    cnt_nxt      = '0;
                end else if (tx_done_tick) begin
                    state_nxt = SEND;
                end else if (cnt == CNT_LAST) begin
                    err_nxt    = 1'b1;
                    grant_nxt  = '0;
                    rr_ptr_nxt = rr_inc;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, DBIT=8, TIMEOUT_CYC=16); the transmitter's
// done tick is driven by hand. Build with UART_TX_ARB_ID_HDR_EN to exercise the header path.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic        busy;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int order [5];
        order = '{1, 2, 3, 0, 1};
        reset_n      = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_done_tick = 1'b0;
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_din", tx_din, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ready", req_ready, 0);
        reset_n = 1'b1;

`ifndef UART_TX_ARB_ID_HDR_EN
        // Single-byte packet from requester 0
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = 4'b0001;
        step();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_busy", busy, 1);
        chk("t1_nostart", tx_start, 0);
        step();
        chk("t1_start", tx_start, 1);
        chk("t1_din", tx_din, 8'hA5);
        chk("t1_ready_off", req_ready, 0);
        req_valid = 4'b0000;
        step();
        chk("t1_start_off", tx_start, 0);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t1_release", grant, 0);
        chk("t1_idle", busy, 0);

        // All four valid: rr_ptr is now 1, so order is 1,2,3,0,1
        req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h44332211;
        for (int p = 0; p < 5; p++) begin
            step();
            chk("t2_grant", grant, 32'(1) << order[p]);
            chk("t2_ready", req_ready, 32'(1) << order[p]);
            step();
            chk("t2_start", tx_start, 1);
            chk("t2_din", tx_din, 32'h11 * (order[p] + 1));
            tx_done_tick = 1'b1;
            step();
            tx_done_tick = 1'b0;
            chk("t2_one_start", tx_start, 0);
            chk("t2_release", grant, 0);
        end

        // Three-byte packet from requester 2 while requester 1 waits
        req_valid = 4'b0110; req_last = 4'b1011; req_data[23:16] = 8'h11;
        step();
        chk("t3_grant", grant, 4'b0100);
        step();
        chk("t3_din0", tx_din, 8'h11);
        req_data[23:16] = 8'h22;
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t3_ready1", req_ready, 4'b0100);
        chk("t3_lock1", grant, 4'b0100);
        step();
        chk("t3_din1", tx_din, 8'h22);
        req_data[23:16] = 8'h33; req_last = 4'b1111;
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t3_ready2", req_ready, 4'b0100);
        step();
        chk("t3_din2", tx_din, 8'h33);
        chk("t3_start2", tx_start, 1);
        req_valid = 4'b0010;
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t3_release", grant, 0);
        step();
        chk("t3_next", grant, 4'b0010);
        step();
        chk("t3_next_din", tx_din, 8'h22);
        req_valid = 4'b0000;
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t3_done", grant, 0);

        // Owner 3 stalls after a non-last byte: HOLD, abort 16 cycles later
        req_valid = 4'b1000; req_last = 4'b0111; req_data[31:24] = 8'h5C;
        step();
        chk("t4_grant", grant, 4'b1000);
        step();
        chk("t4_din", tx_din, 8'h5C);
        req_valid = 4'b0000;
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t4_hold_busy", busy, 1);
        req_valid = 4'b0001; req_data[7:0] = 8'hA5;
        for (int c = 1; c < 16; c++) begin
            step();
            chk("t4_no_err", err_timeout, 0);
            chk("t4_locked", grant, 4'b1000);
            chk("t4_no_ready", req_ready, 0);
        end
        step();
        chk("t4_err", err_timeout, 1);
        chk("t4_grant_clr", grant, 0);
        step();
        chk("t4_err_pulse", err_timeout, 0);
        chk("t4_next", grant, 4'b0001);
        step();
        chk("t4_next_start", tx_start, 1);

        // Done tick withheld in WAIT: abort after 16 cycles
        req_valid = 4'b0000;
        for (int c = 1; c < 16; c++) begin
            step();
            chk("t5_no_err", err_timeout, 0);
        end
        step();
        chk("t5_err", err_timeout, 1);
        chk("t5_grant_clr", grant, 0);
        chk("t5_idle", busy, 0);

        // Done tick in the expiry cycle wins
        req_valid = 4'b0010;
        step();
        chk("t5b_grant", grant, 4'b0010);
        step();
        req_valid = 4'b0000;
        for (int c = 1; c < 16; c++) step();
        chk("t5b_still_wait", busy, 1);
        tx_done_tick = 1'b1;
        step();
        chk("t5b_no_err", err_timeout, 0);
        chk("t5b_release", grant, 0);
        step();
        tx_done_tick = 1'b0;
        chk("t5b_late_tick", busy, 0);
        chk("t5b_late_err", err_timeout, 0);
`else
        // Header byte carries the owner index before the data byte
        req_valid = 4'b1000; req_data[31:24] = 8'h5C; req_last = 4'b1000;
        step();
        chk("t6_grant", grant, 4'b1000);
        chk("t6_no_ready", req_ready, 0);
        step();
        chk("t6_hdr_start", tx_start, 1);
        chk("t6_hdr_din", tx_din, 8'h03);
        step();
        chk("t6_hdr_start_off", tx_start, 0);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t6_ready", req_ready, 4'b1000);
        step();
        chk("t6_data_start", tx_start, 1);
        chk("t6_data_din", tx_din, 8'h5C);
        req_valid = 4'b0000;
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("t6_release", grant, 0);
        chk("t6_err", err_timeout, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
